dnoc_itf_multibuf: RTL and testbench
====================================

# dnoc_itf_multibuf

Parametrised N-slot buffer-status tracker for the DNoC interface. It generalises the two-slot ping-pong scheme to BUF_NUM slots. It tracks which slots hold valid data from producer write-done and consumer read-done pulses, keeps independent wrapping write/read pointers, and reports occupancy, full/empty/almost-full and sticky protocol-error flags. It sits between the DNoC write engine and the core-side reader, alongside the interface buffer RAM.

## Interface
- BUF_NUM, 2, number of buffer slots; legal range 2..16, need not be a power of two
- AFULL_TH, BUF_NUM-1, occupancy at or above which almost_full asserts; legal range 1..BUF_NUM
- PTR_W (localparam), $clog2(BUF_NUM), pointer width
- CNT_W (localparam), $clog2(BUF_NUM+1), occupancy width

Ports:
- clk  in  1  clock; every register uses the rising edge
- rst_n  in  1  synchronous, active-low reset
- clr  in  1  synchronous soft clear; same effect as reset
- wr_done  in  1  single-cycle pulse: producer finished filling slot wr_ptr
- rd_done  in  1  single-cycle pulse: consumer finished draining slot rd_ptr
- buf_state  out  BUF_NUM  bit i = 1 means slot i is full
- wr_ptr  out  PTR_W  next slot the producer fills
- rd_ptr  out  PTR_W  next slot the consumer drains
- count  out  CNT_W  number of full slots
- full, empty, almost_full  out  1  status flags
- wr_ready  out  1  equals ~full
- rd_valid  out  1  equals ~empty
- ovf_err  out  1  sticky flag: wr_done arrived while full
- udf_err  out  1  sticky flag: rd_done arrived while empty

## Operation
- Reset or clr:
  - buf_state=0, wr_ptr=0, rd_ptr=0, count=0.
  - ovf_err=0, udf_err=0.
  - Resulting flags: empty=1, full=0, almost_full=0, wr_ready=1, rd_valid=0.
  - rst_n has priority over clr. clr has priority over wr_done/rd_done in the same cycle.
- Acceptance is judged against the registered state only. There is no same-cycle bypass.
  - A write is accepted when wr_done & ~full.
  - A read is accepted when rd_done & ~empty.
- Accepted write:
  - buf_state[wr_ptr] is set.
  - wr_ptr advances; it wraps from BUF_NUM-1 to 0.
- Accepted read:
  - buf_state[rd_ptr] is cleared.
  - rd_ptr advances with the same wrap rule.
- count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Both accepted in one cycle: they always address different slots, because the state is neither full nor empty. Both slot updates apply.
- Full and both pulses in one cycle: only the read is accepted. ovf_err is set and the write is dropped, with no slot or pointer change. Next cycle count = BUF_NUM-1.
- Empty and both pulses in one cycle: only the write is accepted. udf_err is set. Next cycle count = 1.
- A rejected pulse changes nothing except its sticky error flag. Errors clear only on reset or clr.
- Derived flags: full = (count==BUF_NUM), empty = (count==0), almost_full = (count>=AFULL_TH).
- Invariant, checked by assertion: popcount(buf_state)==count, and wr_ptr == (rd_ptr+count) mod BUF_NUM.

## Timing
- Every state register updates on the rising edge after the pulse. Latency from pulse to buf_state, pointer and count change is 1 cycle.
- Status flags (full, empty, almost_full, wr_ready, rd_valid) are combinational decodes of the registered count. They are valid in the same cycle count changes, with no further delay.
- Back-to-back pulses every cycle are supported. Throughput is one write and one read per cycle.
- Reset and clr each take effect at the first rising edge where they are sampled active. Outputs show reset values from that edge onward.
- wr_done or rd_done held high for several cycles counts as one event per cycle.

## Structure
- Shared package dnoc_itf_pkg holds:
  - BUF_NUM_MAX=16;
  - the function next_ptr(ptr, num), which performs the wrap increment.
- Sub-module dnoc_itf_ring_ptr: a parametrised wrapping pointer with an increment enable and synchronous clear. It is instantiated twice, once for wr_ptr and once for rd_ptr.
- The top level holds the accept logic, buf_state, count, error flags and status decode.

## Test plan
- Reset: with BUF_NUM=3, drive rst_n=0 for 2 cycles then 1 → buf_state=3'b000, count=0, empty=1, wr_ready=1, rd_valid=0, ovf_err=0, udf_err=0.
- Fill/wrap: with BUF_NUM=3, apply 3 wr_done then 3 rd_done, then one more wr_done →
  - buf_state goes 001, 011, 111; full=1 after the 3rd write;
  - after the reads, empty=1 and both pointers are 0;
  - after the extra write, buf_state=001.
- Overflow: with BUF_NUM=4 and full, drive wr_done+rd_done together → count=3, rd_ptr=1, wr_ptr=0, ovf_err=1, buf_state=4'b1110.
- Underflow: when empty, drive rd_done alone → udf_err=1, no other change. Then drive wr_done+rd_done together → count=1, buf_state[wr_ptr]=1.
- Steady streaming: with BUF_NUM=2, one write first, then wr_done and rd_done together for 10 cycles → count stays 1, buf_state alternates 01/10 with the pointers, no errors. With AFULL_TH=1, almost_full=1 throughout.
- clr mid-operation: with count=2 and ovf_err=1, drive clr together with wr_done → the next cycle shows reset values and the write is ignored.

Source files
------------

// File: rtl/dnoc_itf_pkg.sv
// Shared definitions for the DNoC interface buffer tracking logic.
//   BUF_NUM_MAX : largest supported slot count
//   next_ptr()  : wrapping increment of a slot pointer (wraps num-1 -> 0)
package dnoc_itf_pkg;

    localparam int unsigned BUF_NUM_MAX = 16;
    localparam int unsigned PTR_W_MAX   = $clog2(BUF_NUM_MAX);

    function automatic logic [PTR_W_MAX-1:0] next_ptr(
        input logic [PTR_W_MAX-1:0] ptr,
        input int unsigned          num
    );
        if (ptr == PTR_W_MAX'(num - 1))
            return '0;
        else
            return ptr + PTR_W_MAX'(1);
    endfunction

endpackage

// File: rtl/dnoc_itf_ring_ptr.sv
// Wrapping slot pointer with increment enable and synchronous clear.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear, same effect as reset
//   inc   : advance the pointer by one slot (wraps NUM-1 -> 0)
//   ptr   : current pointer value
module dnoc_itf_ring_ptr
    import dnoc_itf_pkg::*;
#(
    parameter int unsigned NUM   = 2,
    parameter int unsigned PTR_W = $clog2(NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W_MAX-1:0] ptr_ext;
    logic [PTR_W-1:0]     ptr_nxt;

    assign ptr_ext = PTR_W_MAX'(ptr);
    assign ptr_nxt = PTR_W'(next_ptr(ptr_ext, NUM));

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/dnoc_itf_multibuf.sv
// N-slot buffer-status tracker for the DNoC interface.
// Tracks which of BUF_NUM slots hold data from producer write-done and
// consumer read-done pulses, with independent wrapping pointers,
// occupancy count, status flags and sticky protocol-error flags.
// Ports:
//   clk, rst_n (sync, active-low), clr (sync soft clear)
//   wr_done / rd_done : single-cycle completion pulses for wr_ptr / rd_ptr
//   buf_state         : bit i set when slot i is full
//   wr_ptr / rd_ptr   : next slot to fill / drain
//   count             : number of full slots
//   full, empty, almost_full, wr_ready (~full), rd_valid (~empty)
//   ovf_err / udf_err : sticky, write while full / read while empty
module dnoc_itf_multibuf
    import dnoc_itf_pkg::*;
#(
    parameter int unsigned BUF_NUM  = 2,
    parameter int unsigned AFULL_TH = BUF_NUM - 1,
    localparam int unsigned PTR_W   = $clog2(BUF_NUM),
    localparam int unsigned CNT_W   = $clog2(BUF_NUM + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               wr_done,
    input  logic               rd_done,
    output logic [BUF_NUM-1:0] buf_state,
    output logic [PTR_W-1:0]   wr_ptr,
    output logic [PTR_W-1:0]   rd_ptr,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               wr_ready,
    output logic               rd_valid,
    output logic               ovf_err,
    output logic               udf_err
);

    logic               wr_acc;
    logic               rd_acc;
    logic [BUF_NUM-1:0] wr_mask;
    logic [BUF_NUM-1:0] rd_mask;

    // Acceptance uses registered state only; full and empty can never both
    // hold, so a simultaneous accept always touches two distinct slots.
    assign wr_acc = wr_done & ~full;
    assign rd_acc = rd_done & ~empty;

    always_comb begin
        wr_mask = '0;
        rd_mask = '0;
        for (int i = 0; i < int'(BUF_NUM); i++) begin
            wr_mask[i] = wr_acc && (wr_ptr == PTR_W'(i));
            rd_mask[i] = rd_acc && (rd_ptr == PTR_W'(i));
        end
    end

    dnoc_itf_ring_ptr #(.NUM(BUF_NUM), .PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    dnoc_itf_ring_ptr #(.NUM(BUF_NUM), .PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            buf_state <= '0;
            count     <= '0;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else begin
            buf_state <= (buf_state | wr_mask) & ~rd_mask;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            ovf_err <= ovf_err | (wr_done & full);
            udf_err <= udf_err | (rd_done & empty);
        end
    end

    assign full        = (count == CNT_W'(BUF_NUM));
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AFULL_TH));
    assign wr_ready    = ~full;
    assign rd_valid    = ~empty;

    a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
        ($countones(buf_state) == int'(count)));

    a_ptr_gap: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(wr_ptr) == ((int'(rd_ptr) + int'(count)) % int'(BUF_NUM))));

endmodule

// File: tb/tb_dnoc_itf_multibuf.sv
module tb_dnoc_itf_multibuf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic wr_done = 1'b0;
    logic rd_done = 1'b0;

    always #5 clk = ~clk;

    // Three configurations driven by the same stimulus.
    logic [2:0] bs3;  logic [1:0] wp3, rp3;  logic [1:0] cnt3;
    logic fl3, em3, af3, wy3, rv3, ov3, ud3;
    logic [3:0] bs4;  logic [1:0] wp4, rp4;  logic [2:0] cnt4;
    logic fl4, em4, af4, wy4, rv4, ov4, ud4;
    logic [1:0] bs2;  logic [0:0] wp2, rp2;  logic [1:0] cnt2;
    logic fl2, em2, af2, wy2, rv2, ov2, ud2;

    dnoc_itf_multibuf #(.BUF_NUM(3), .AFULL_TH(2)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_done(wr_done), .rd_done(rd_done),
        .buf_state(bs3), .wr_ptr(wp3), .rd_ptr(rp3), .count(cnt3),
        .full(fl3), .empty(em3), .almost_full(af3), .wr_ready(wy3), .rd_valid(rv3),
        .ovf_err(ov3), .udf_err(ud3));

    dnoc_itf_multibuf #(.BUF_NUM(4)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_done(wr_done), .rd_done(rd_done),
        .buf_state(bs4), .wr_ptr(wp4), .rd_ptr(rp4), .count(cnt4),
        .full(fl4), .empty(em4), .almost_full(af4), .wr_ready(wy4), .rd_valid(rv4),
        .ovf_err(ov4), .udf_err(ud4));

    dnoc_itf_multibuf #(.BUF_NUM(2), .AFULL_TH(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_done(wr_done), .rd_done(rd_done),
        .buf_state(bs2), .wr_ptr(wp2), .rd_ptr(rp2), .count(cnt2),
        .full(fl2), .empty(em2), .almost_full(af2), .wr_ready(wy2), .rd_valid(rv2),
        .ovf_err(ov2), .udf_err(ud2));

    // Reference model: a ring described only by its read position and
    // occupancy; everything else is derived arithmetically.
    int num [3] = '{3, 4, 2};
    int th  [3] = '{2, 3, 1};
    int m_rd [3];
    int m_cnt[3];
    int m_ovf[3];
    int m_udf[3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic w, input logic r, input logic c, input logic rn);
        for (int i = 0; i < 3; i++) begin
            if (!rn || c) begin
                m_rd[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
            end else begin
                int wa, ra;
                wa = (w && m_cnt[i] != num[i]) ? 1 : 0;
                ra = (r && m_cnt[i] != 0) ? 1 : 0;
                if (w && m_cnt[i] == num[i]) m_ovf[i] = 1;
                if (r && m_cnt[i] == 0)      m_udf[i] = 1;
                m_rd[i]  = (m_rd[i] + ra) % num[i];
                m_cnt[i] = m_cnt[i] + wa - ra;
            end
        end
    endtask

    task automatic chk_inst(input int i, input string nm,
                            input logic [31:0] bs, input logic [31:0] wp,
                            input logic [31:0] rp, input logic [31:0] cnt,
                            input logic fl, input logic em, input logic af,
                            input logic wy, input logic rv, input logic ov, input logic ud);
        logic [31:0] ebs;
        ebs = 0;
        for (int k = 0; k < m_cnt[i]; k++) ebs[(m_rd[i] + k) % num[i]] = 1'b1;
        chk({nm, "_buf_state"}, bs, ebs);
        chk({nm, "_wr_ptr"}, wp, 32'((m_rd[i] + m_cnt[i]) % num[i]));
        chk({nm, "_rd_ptr"}, rp, 32'(m_rd[i]));
        chk({nm, "_count"}, cnt, 32'(m_cnt[i]));
        chk({nm, "_full"}, 32'(fl), 32'(m_cnt[i] == num[i]));
        chk({nm, "_empty"}, 32'(em), 32'(m_cnt[i] == 0));
        chk({nm, "_afull"}, 32'(af), 32'(m_cnt[i] >= th[i]));
        chk({nm, "_wr_ready"}, 32'(wy), 32'(m_cnt[i] != num[i]));
        chk({nm, "_rd_valid"}, 32'(rv), 32'(m_cnt[i] != 0));
        chk({nm, "_ovf"}, 32'(ov), 32'(m_ovf[i]));
        chk({nm, "_udf"}, 32'(ud), 32'(m_udf[i]));
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic rn);
        wr_done = w; rd_done = r; clr = c; rst_n = rn;
        @(posedge clk);
        model_update(w, r, c, rn);
        #1;
        chk_inst(0, "b3", 32'(bs3), 32'(wp3), 32'(rp3), 32'(cnt3), fl3, em3, af3, wy3, rv3, ov3, ud3);
        chk_inst(1, "b4", 32'(bs4), 32'(wp4), 32'(rp4), 32'(cnt4), fl4, em4, af4, wy4, rv4, ov4, ud4);
        chk_inst(2, "b2", 32'(bs2), 32'(wp2), 32'(rp2), 32'(cnt2), fl2, em2, af2, wy2, rv2, ov2, ud2);
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("rst_bs", 32'(bs3), 32'b000);
        chk("rst_cnt", 32'(cnt3), 0);
        chk("rst_empty", 32'(em3), 1);
        chk("rst_wr_ready", 32'(wy3), 1);
        chk("rst_rd_valid", 32'(rv3), 0);
        chk("rst_errs", {30'd0, ov3, ud3}, 0);

        // Fill / wrap on 3 slots
        step(1, 0, 0, 1);  chk("fill_bs1", 32'(bs3), 32'b001);
        step(1, 0, 0, 1);  chk("fill_bs2", 32'(bs3), 32'b011);
        step(1, 0, 0, 1);  chk("fill_bs3", 32'(bs3), 32'b111);
        chk("fill_full", 32'(fl3), 1);
        repeat (3) step(0, 1, 0, 1);
        chk("drain_empty", 32'(em3), 1);
        chk("drain_ptrs", {28'd0, wp3, rp3}, 0);
        step(1, 0, 0, 1);  chk("wrap_bs", 32'(bs3), 32'b001);

        // Overflow on 4 slots
        step(0, 0, 1, 1);
        repeat (4) step(1, 0, 0, 1);
        chk("ovf_pre_full", 32'(fl4), 1);
        step(1, 1, 0, 1);
        chk("ovf_cnt", 32'(cnt4), 3);
        chk("ovf_rd_ptr", 32'(rp4), 1);
        chk("ovf_wr_ptr", 32'(wp4), 0);
        chk("ovf_flag", 32'(ov4), 1);
        chk("ovf_bs", 32'(bs4), 32'b1110);

        // Underflow
        step(0, 0, 1, 1);
        step(0, 1, 0, 1);
        chk("udf_flag", 32'(ud4), 1);
        chk("udf_cnt", 32'(cnt4), 0);
        chk("udf_bs", 32'(bs4), 0);
        step(1, 1, 0, 1);
        chk("udf_both_cnt", 32'(cnt4), 1);
        chk("udf_both_bs", 32'(bs4), 32'b0001);

        // Steady streaming on 2 slots
        step(0, 0, 1, 1);
        step(1, 0, 0, 1);
        chk("strm_bs0", 32'(bs2), 32'b01);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 1);
            chk("strm_bs", 32'(bs2), (i % 2 == 0) ? 32'b10 : 32'b01);
            chk("strm_cnt", 32'(cnt2), 1);
            chk("strm_afull", 32'(af2), 1);
            chk("strm_errs", {30'd0, ov2, ud2}, 0);
        end

        // clr mid-operation
        step(0, 0, 1, 1);
        repeat (3) step(1, 0, 0, 1);
        chk("clr_pre_cnt", 32'(cnt2), 2);
        chk("clr_pre_ovf", 32'(ov2), 1);
        step(1, 0, 1, 1);
        chk("clr_cnt", 32'(cnt2), 0);
        chk("clr_bs", 32'(bs2), 0);
        chk("clr_ovf", 32'(ov2), 0);
        chk("clr_wr_ptr", 32'(wp2), 0);

        // Randomised traffic with phase-dependent bias
        for (int n = 0; n < 3000; n++) begin
            int wp, rpb;
            wp  = ((n / 300) % 3 == 0) ? 75 : (((n / 300) % 3 == 1) ? 30 : 50);
            rpb = 100 - wp;
            step(($urandom_range(0, 99) < wp)  ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < rpb) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
